// File: rtl/cmp_scan_pkg.sv
// Shared types and helpers for the comparator self-test sequencer.
// Holds the scan state encoding, pair count and golden comparator model.
package cmp_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DONE
    } scan_state_e;

    localparam int unsigned NUM_PAIRS = 16;
    localparam logic [3:0]  NO_FAIL   = 4'hF;
    localparam logic [3:0]  LAST_IDX  = 4'(NUM_PAIRS - 1);

    // Expected {red, green, blue} for a correct 2-bit magnitude comparator.
    function automatic logic [2:0] golden_rgb(input logic [1:0] a, input logic [1:0] b);
        return {(a >= b), (a <= b), (a != b)};
    endfunction

endpackage

// File: rtl/cmp_scan_hold_cnt.sv
// Hold counter: counts 0..HOLD_CYCLES-1 while enabled, wraps on terminal count.
// tc_o flags the final cycle of each hold window.
module cmp_scan_hold_cnt #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cmp_scan_ctrl.sv
// Self-test sequencer stepping a 2-bit comparator through all 16 (a,b) pairs.
// Optional result log with read port is enabled by defining CMP_SCAN_LOG_EN.
module cmp_scan_ctrl
    import cmp_scan_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       red_i,
    input  logic       green_i,
    input  logic       blue_i,
    output logic [1:0] a_o,
    output logic [1:0] b_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_fail
`ifdef CMP_SCAN_LOG_EN
    ,
    input  logic [3:0] rd_idx,
    output logic [2:0] rd_rgb
`endif
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    scan_state_e state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  ff_q, ff_d;

    logic        hold_tc;
    logic        hold_en;
    logic        hold_clr;
    logic [2:0]  sample_rgb;
    logic        mismatch;

    assign sample_rgb = {red_i, green_i, blue_i};
    assign mismatch   = (sample_rgb != golden_rgb(idx_q[3:2], idx_q[1:0]));

    // Counter only advances in an uninterrupted HOLD; any other state parks it at 0.
    assign hold_en  = (state_q == HOLD) && !abort;
    assign hold_clr = (state_q != HOLD) || abort;

    cmp_scan_hold_cnt #(
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (HOLD_W)
    ) u_hold_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(hold_clr),
        .en_i (hold_en),
        .tc_o (hold_tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (start && !abort) begin
                    state_d = HOLD;
                    err_d   = '0;
                    ff_d    = NO_FAIL;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (hold_tc) begin
                    if (mismatch) begin
                        err_d = err_q + 5'd1;
                        if (ff_q == NO_FAIL) begin
                            ff_d = idx_q;
                        end
                    end
                    // pass must see the last pair's result, hence err_d not err_q.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= NO_FAIL;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign a_o        = idx_q[3:2];
    assign b_o        = idx_q[1:0];
    assign busy       = (state_q == HOLD);
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;

`ifdef CMP_SCAN_LOG_EN
    logic [2:0] log_q [NUM_PAIRS];
    logic [2:0] rd_rgb_q;
    logic       scan_accept;
    logic       sample_en;

    assign scan_accept = (state_q == IDLE) && start && !abort;
    assign sample_en   = hold_en && hold_tc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PAIRS; i++) begin
                log_q[i] <= '0;
            end
            rd_rgb_q <= '0;
        end else begin
            if (scan_accept) begin
                for (int unsigned i = 0; i < NUM_PAIRS; i++) begin
                    log_q[i] <= '0;
                end
            end else if (sample_en) begin
                log_q[idx_q] <= sample_rgb;
            end
            rd_rgb_q <= log_q[rd_idx];
        end
    end

    assign rd_rgb = rd_rgb_q;
`endif

endmodule

// File: tb/tb_cmp_scan_ctrl.sv
// Directed self-checking bench for cmp_scan_ctrl (HOLD_CYCLES=4 and HOLD_CYCLES=1 instances).
// Comparator faults are injected through a behavioural model selected by fault_mode.
module tb_cmp_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic       red, green, blue;
    logic [1:0] a_o, b_o;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
    logic [3:0] first_fail;

    logic       start1;
    logic       red1, green1, blue1;
    logic [1:0] a1, b1;
    logic       busy1, done1, pass1;
    logic [4:0] err1;
    logic [3:0] ff1;

    int         fault_mode;
    int         n_tests = 0;
    int         n_fail  = 0;

`ifdef CMP_SCAN_LOG_EN
    logic [3:0] rd_idx;
    logic [2:0] rd_rgb;
    logic [2:0] rd_rgb1;
`endif

    always #5 clk = ~clk;

    // 0: correct comparator, 1: blue stuck-at-0, 2: red stuck-at-1
    always_comb begin
        red   = (a_o >= b_o);
        green = (a_o <= b_o);
        blue  = (a_o != b_o);
        if (fault_mode == 1) blue = 1'b0;
        if (fault_mode == 2) red  = 1'b1;
    end

    always_comb begin
        red1   = (a1 >= b1);
        green1 = (a1 <= b1);
        blue1  = (a1 != b1);
    end

    cmp_scan_ctrl #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .red_i(red), .green_i(green), .blue_i(blue),
        .a_o(a_o), .b_o(b_o), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail)
`ifdef CMP_SCAN_LOG_EN
        , .rd_idx(rd_idx), .rd_rgb(rd_rgb)
`endif
    );

    cmp_scan_ctrl #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .red_i(red1), .green_i(green1), .blue_i(blue1),
        .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail(ff1)
`ifdef CMP_SCAN_LOG_EN
        , .rd_idx(4'd0), .rd_rgb(rd_rgb1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; fault_mode = 0;
`ifdef CMP_SCAN_LOG_EN
        rd_idx = 4'd0;
`endif
        tick(); tick();
        n_tests++;
        if ({busy, done, pass, err_cnt, first_fail, a_o, b_o} !== {3'b000, 5'd0, 4'hF, 4'h0}) begin
            n_fail++;
            $display("FAIL reset: busy/done/pass/err/ff/a/b=%b/%b/%b/%0d/%h/%0d/%0d expected 0/0/0/0/f/0/0",
                     busy, done, pass, err_cnt, first_fail, a_o, b_o);
        end
        n_tests++;
        if ({busy1, done1, err1, ff1} !== {2'b00, 5'd0, 4'hF}) begin
            n_fail++;
            $display("FAIL reset_h1: busy/done/err/ff=%b/%b/%0d/%h expected 0/0/0/f", busy1, done1, err1, ff1);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Full 64-cycle scan from IDLE; pulse_at >= 1 re-asserts start mid-scan.
    task automatic run_scan(input string nm, input int m, input logic [4:0] ee,
                            input logic [3:0] ef, input logic ep, input int pulse_at);
        logic [3:0] e;
        fault_mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({busy, err_cnt, first_fail, a_o, b_o} !== {1'b1, 5'd0, 4'hF, 4'h0}) begin
            n_fail++;
            $display("FAIL %s_accept: busy/err/ff/ab=%b/%0d/%h/%h expected 1/0/f/0", nm, busy, err_cnt, first_fail, {a_o, b_o});
        end
        for (int t = 1; t < 64; t++) begin
            if (t == pulse_at) start = 1'b1;
            tick();
            start = 1'b0;
            e = 4'(t / 4);
            n_tests++;
            if ({a_o, b_o} !== e) begin
                n_fail++;
                $display("FAIL %s_step t=%0d: ab=%h expected %h", nm, t, {a_o, b_o}, e);
            end
        end
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_early: done/busy=%b/%b at edge 63 expected 0/1", nm, done, busy);
        end
        tick();
        n_tests++;
        if ({done, busy, pass, err_cnt, first_fail} !== {1'b1, 1'b0, ep, ee, ef}) begin
            n_fail++;
            $display("FAIL %s_done: done/busy/pass/err/ff=%b/%b/%b/%0d/%h expected 1/0/%b/%0d/%h",
                     nm, done, busy, pass, err_cnt, first_fail, ep, ee, ef);
        end
        tick();
        n_tests++;
        if ({done, busy, pass, err_cnt, first_fail, a_o, b_o} !== {1'b1, 1'b0, ep, ee, ef, 4'h0}) begin
            n_fail++;
            $display("FAIL %s_sticky: done/busy/pass/err/ff/ab=%b/%b/%b/%0d/%h/%h expected 1/0/%b/%0d/%h/0",
                     nm, done, busy, pass, err_cnt, first_fail, {a_o, b_o}, ep, ee, ef);
        end
    endtask

    task automatic test_clean_scan();
        run_scan("clean", 0, 5'd0, 4'hF, 1'b1, -1);
    endtask

    task automatic test_blue_stuck();
        run_scan("blue0", 1, 5'd12, 4'h1, 1'b0, -1);
`ifdef CMP_SCAN_LOG_EN
        rd_idx = 4'd1;
        tick(); tick();
        n_tests++;
        if (rd_rgb !== 3'b010) begin
            n_fail++;
            $display("FAIL log_idx1: rd_rgb=%b expected 010", rd_rgb);
        end
        rd_idx = 4'd4;
        tick(); tick();
        n_tests++;
        if (rd_rgb !== 3'b100) begin
            n_fail++;
            $display("FAIL log_idx4: rd_rgb=%b expected 100", rd_rgb);
        end
        rd_idx = 4'd0;
`endif
    endtask

    task automatic test_red_stuck();
        run_scan("red1", 2, 5'd6, 4'h1, 1'b0, -1);
    endtask

    task automatic test_abort();
        fault_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t < 10; t++) tick();
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        n_tests++;
        if ({busy, done, a_o, b_o, err_cnt, first_fail} !== {2'b00, 4'h0, 5'd1, 4'h1}) begin
            n_fail++;
            $display("FAIL abort: busy/done/ab/err/ff=%b/%b/%h/%0d/%h expected 0/0/0/1/1",
                     busy, done, {a_o, b_o}, err_cnt, first_fail);
        end
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || err_cnt !== 5'd1) begin
            n_fail++;
            $display("FAIL abort_blocks_start: busy/err=%b/%0d expected 0/1", busy, err_cnt);
        end
        tick();
        run_scan("after_abort", 0, 5'd0, 4'hF, 1'b1, -1);
    endtask

    task automatic test_restart_ignored();
        run_scan("restart", 0, 5'd0, 4'hF, 1'b1, 20);
    endtask

    task automatic test_reset_mid_scan();
        fault_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t < 30; t++) tick();
        n_tests++;
        if (err_cnt !== 5'd5 || first_fail !== 4'h1) begin
            n_fail++;
            $display("FAIL pre_reset: err/ff=%0d/%h expected 5/1", err_cnt, first_fail);
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({busy, done, pass, err_cnt, first_fail, a_o, b_o} !== {3'b000, 5'd0, 4'hF, 4'h0}) begin
            n_fail++;
            $display("FAIL mid_reset: busy/done/pass/err/ff/ab=%b/%b/%b/%0d/%h/%h expected 0/0/0/0/f/0",
                     busy, done, pass, err_cnt, first_fail, {a_o, b_o});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        fault_mode = 0;
        start = 1'b1;
        tick();
        for (int t = 1; t < 64; t++) tick();
        tick();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: done/busy=%b/%b expected 1/0", done, busy);
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: done/busy=%b/%b expected 1/0", done, busy);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: done/busy=%b/%b expected 0/1", done, busy);
        end
        start = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_abort: busy/done=%b/%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_hold1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int t = 1; t < 16; t++) begin
            tick();
            n_tests++;
            if ({a1, b1} !== 4'(t)) begin
                n_fail++;
                $display("FAIL h1_step t=%0d: ab=%h expected %h", t, {a1, b1}, 4'(t));
            end
        end
        n_tests++;
        if (done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL h1_early: done=%b at edge 15 expected 0", done1);
        end
        tick();
        n_tests++;
        if ({done1, busy1, pass1, err1, ff1} !== {3'b101, 5'd0, 4'hF}) begin
            n_fail++;
            $display("FAIL h1_done: done/busy/pass/err/ff=%b/%b/%b/%0d/%h expected 1/0/1/0/f",
                     done1, busy1, pass1, err1, ff1);
        end
    endtask

    initial begin
        test_reset();
        test_clean_scan();
        test_blue_stuck();
        test_red_stuck();
        test_abort();
        test_restart_ignored();
        test_reset_mid_scan();
        test_back_to_back();
        test_hold1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
